// File: rtl/dmem_access_ctrl.sv
// Two-port round-robin sequencer in front of a word-wide data memory.
// Sub-word loads are extracted here; SB/SH become read-modify-write sequences.
module dmem_access_ctrl #(
   parameter logic [31:0] DATA_BASE  = 32'h8000_0000,
   parameter int unsigned DATA_BYTES = 4096,
   parameter logic [31:0] SROM_BASE  = 32'h0010_0000,
   parameter int unsigned SROM_WORDS = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        c_req,
   input  logic        c_we,
   input  logic [31:0] c_addr,
   input  logic [31:0] c_wdata,
   input  logic [2:0]  c_type,
   output logic        c_done,
   output logic        c_err,
   output logic [31:0] c_rdata,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   input  logic [2:0]  d_type,
   output logic        d_done,
   output logic        d_err,
   output logic [31:0] d_rdata,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wr_data,
   output logic [2:0]  mem_data_type,
   output logic        mem_read,
   output logic        mem_write,
   input  logic [31:0] mem_rd_data
);

   localparam logic [31:0] DATA_SIZE  = 32'(DATA_BYTES);
   localparam logic [31:0] SROM_BYTES = 32'(SROM_WORDS * 4);

   typedef enum logic [1:0] {IDLE, ACC, MERGE, RESP} state_t;

   function automatic logic is_byte(input logic [2:0] t);
      return (t == 3'b000) || (t == 3'b011);
   endfunction

   function automatic logic is_half(input logic [2:0] t);
      return (t == 3'b001) || (t == 3'b100);
   endfunction

   function automatic logic is_word(input logic [2:0] t);
      return !is_byte(t) && !is_half(t);
   endfunction

   function automatic logic access_err(input logic we, input logic [31:0] a,
                                       input logic [2:0] t);
      logic [31:0] d_off;
      logic [31:0] s_off;
      logic        in_data;
      logic        in_srom;
      logic        misaligned;
      // Offsets wrap below the base, so a single unsigned compare covers both bounds.
      d_off      = a - DATA_BASE;
      s_off      = a - SROM_BASE;
      in_data    = d_off < DATA_SIZE;
      in_srom    = s_off < SROM_BYTES;
      misaligned = (is_half(t) && a[0]) || (is_word(t) && (a[1:0] != 2'b00));
      return misaligned || !(in_data || in_srom) || (we && in_srom);
   endfunction

   function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] lane,
                                           input logic [2:0] t);
      logic [7:0]  b;
      logic [15:0] h;
      logic        sgn;
      b   = w[{lane, 3'b000} +: 8];
      h   = w[{lane[1], 4'b0000} +: 16];
      sgn = (t == 3'b000) || (t == 3'b001);
      if (is_byte(t))      return {{24{sgn & b[7]}}, b};
      else if (is_half(t)) return {{16{sgn & h[15]}}, h};
      else                 return w;
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] w, input logic [1:0] lane,
                                         input logic [2:0] t, input logic [15:0] wd);
      logic [31:0] r;
      r = w;
      if (is_byte(t)) r[{lane, 3'b000} +: 8] = wd[7:0];
      else            r[{lane[1], 4'b0000} +: 16] = wd;
      return r;
   endfunction

   state_t      state;
   logic        last_d;
   logic        sel_d;
   logic        we_q;
   logic [1:0]  lane_q;
   logic [15:0] wdata_q;
   logic [2:0]  type_q;

   logic        grant_d;
   logic        g_we;
   logic [31:0] g_addr;
   logic [31:0] g_wdata;
   logic [2:0]  g_type;
   logic        g_err;
   logic        fin;
   logic        fin_d;
   logic        fin_err;
   logic        fin_ld;
   logic [31:0] fin_data;

   assign mem_data_type = 3'b010;

   // NOTE: every signal assigned here gets a default first, so no path leaves one unassigned and no latch is inferred.
   always_comb begin
      grant_d  = d_req && (!c_req || !last_d);
      g_we     = grant_d ? d_we    : c_we;
      g_addr   = grant_d ? d_addr  : c_addr;
      g_wdata  = grant_d ? d_wdata : c_wdata;
      g_type   = grant_d ? d_type  : c_type;
      g_err    = access_err(g_we, g_addr, g_type);
      fin      = 1'b0;
      fin_d    = sel_d;
      fin_err  = 1'b0;
      fin_ld   = 1'b0;
      fin_data = 32'h0;
      case (state)
         IDLE: begin
            if ((c_req || d_req) && g_err) begin
               fin     = 1'b1;
               fin_d   = grant_d;
               fin_err = 1'b1;
               fin_ld  = !g_we;
            end
         end
         ACC: begin
            if (!(we_q && !is_word(type_q))) begin
               fin      = 1'b1;
               fin_ld   = !we_q;
               fin_data = extract(mem_rd_data, lane_q, type_q);
            end
         end
         MERGE:   fin = 1'b1;
         default: fin = 1'b0;
      endcase
   end

   // NOTE: all state and registered outputs use non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         last_d      <= 1'b1;
         sel_d       <= 1'b0;
         we_q        <= 1'b0;
         lane_q      <= 2'b00;
         wdata_q     <= 16'h0;
         type_q      <= 3'b000;
         c_done      <= 1'b0;
         c_err       <= 1'b0;
         c_rdata     <= 32'h0;
         d_done      <= 1'b0;
         d_err       <= 1'b0;
         d_rdata     <= 32'h0;
         mem_addr    <= 32'h0;
         mem_wr_data <= 32'h0;
         mem_read    <= 1'b0;
         mem_write   <= 1'b0;
      end else begin
         c_done    <= 1'b0;
         c_err     <= 1'b0;
         d_done    <= 1'b0;
         d_err     <= 1'b0;
         mem_read  <= 1'b0;
         mem_write <= 1'b0;
         case (state)
            IDLE: begin
               if (c_req || d_req) begin
                  sel_d   <= grant_d;
                  last_d  <= grant_d;
                  we_q    <= g_we;
                  lane_q  <= g_addr[1:0];
                  wdata_q <= g_wdata[15:0];
                  type_q  <= g_type;
                  if (g_err) begin
                     state <= RESP;
                  end else begin
                     state    <= ACC;
                     mem_addr <= {g_addr[31:2], 2'b00};
                     if (g_we && is_word(g_type)) begin
                        mem_write   <= 1'b1;
                        mem_wr_data <= g_wdata;
                     end else begin
                        mem_read <= 1'b1;
                     end
                  end
               end
            end
            ACC: begin
               if (we_q && !is_word(type_q)) begin
                  mem_write   <= 1'b1;
                  mem_wr_data <= merge(mem_rd_data, lane_q, type_q, wdata_q);
                  state       <= MERGE;
               end else begin
                  state <= RESP;
               end
            end
            MERGE:   state <= RESP;
            RESP:    state <= IDLE;
            default: state <= IDLE;
         endcase
         if (fin) begin
            if (fin_d) begin
               d_done <= 1'b1;
               d_err  <= fin_err;
               if (fin_ld) d_rdata <= fin_data;
            end else begin
               c_done <= 1'b1;
               c_err  <= fin_err;
               if (fin_ld) c_rdata <= fin_data;
            end
         end
      end
   end

endmodule
